prog_run_ctrl: RTL
==================

PROG_RUN_CTRL -- requirements
Module: prog_run_ctrl

Interface
REQ-001 Parameter DW, 8, data memory word width in bits.
REQ-002 Parameter AW, 8, data memory address width; DEPTH = 2**AW words.
REQ-003 Parameter NRES, 3, number of result words dumped after the run.
REQ-004 Parameter RES_BASE, 4, first result address.
REQ-005 Parameter TIMEOUT, 100000, run-cycle limit before forced stop.
REQ-006 Parameter CW, 32, cycle counter width.
REQ-007 Port CLK  in  1  single clock; all state changes on its rising edge.
REQ-008 Port Reset  in  1  asynchronous, active-high reset.
REQ-009 Port go  in  1  one-cycle request to start a clear/load/run/dump sequence.
REQ-010 Port pre_valid  in  1; pre_addr  in  AW; pre_data  in  DW; pre_last  in  1  preload write beat.
REQ-011 Port pre_ready  out  1  preload beat accepted this cycle.
REQ-012 Port mem_own  out  1  controller drives data memory port (DUT port muxed off).
REQ-013 Port mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW  data memory write/read request.
REQ-014 Port mem_rdata  in  DW  memory read data, valid one cycle after mem_addr.
REQ-015 Port dut_start  out  1  DUT hold/launch (1 = held, falling edge launches program).
REQ-016 Port dut_halt  in  1  DUT done flag.
REQ-017 Port res_valid  out  1; res_idx  out  $clog2(NRES)+1; res_data  out  DW  result beat.
REQ-018 Port busy, done, timeout  out  1 each; cycles  out  CW  run cycle count.

Function
REQ-019 States IDLE, CLEAR, LOAD, LAUNCH, RUN, DUMP, DONE; go is honoured only in IDLE or DONE, transitioning to CLEAR next edge.
REQ-020 CLEAR: mem_own=1, mem_we=1, mem_wdata=0, mem_addr 0..DEPTH-1 one per cycle (DEPTH cycles), then LOAD.
REQ-021 LOAD: pre_ready=1; each cycle with pre_valid writes pre_data to pre_addr same cycle; beat with pre_last written then LAUNCH; pre_valid low = no write, stay.
REQ-022 LAUNCH lasts exactly 1 cycle with dut_start=1, mem_own=0; RUN entered next edge with dut_start=0; cycles cleared to 0 on LAUNCH.
REQ-023 RUN: mem_own=0, mem_we=0; cycles increments every RUN cycle, saturating at 2**CW-1.
REQ-024 RUN exits to DUMP on dut_halt=1; else on cycles==TIMEOUT-1 sets timeout=1 and exits to DUMP; simultaneous halt and limit: halt wins, timeout=0.
REQ-025 DUMP: mem_own=1, mem_we=0, mem_addr=(RES_BASE+i) mod DEPTH for i=0..NRES-1, one per cycle; res_valid pulses one cycle later with res_idx=i, res_data=mem_rdata; no backpressure; DUMP lasts NRES+1 cycles.
REQ-026 DONE: done=1, dut_start=1, mem_own=0; cycles and timeout hold until next go.
REQ-027 dut_start=1 in every state except RUN; busy=1 in CLEAR through DUMP.
REQ-028 go outside IDLE/DONE ignored; dut_halt outside RUN ignored.

Reset
REQ-029 Reset asserted at any time forces IDLE asynchronously, aborting any in-flight sequence.
REQ-030 Reset values: dut_start=1, all other outputs 0, cycles=0, internal indices 0.

Structure
REQ-031 Package prog_run_pkg holds the state enum and default parameter constants.
REQ-032 Sub-module run_cycle_counter (clear, enable, saturating CW-bit count, limit-hit flag) is instantiated once.

Verification
REQ-033 Reset, go, preload {0:8'h00,1:8'h01,2:8'h01(last)}, halt after 20 RUN cycles -> 256 clear writes, 3 preload writes, cycles=20, res beats idx0..2 with model data, done=1, timeout=0.
REQ-034 TIMEOUT=50, halt never asserted -> timeout=1 after 50 RUN cycles, DUMP still executes, done=1.
REQ-035 dut_halt on same cycle as limit (TIMEOUT=30, halt at cycle 29) -> timeout=0, cycles=30.
REQ-036 pre_valid gaps of 3 cycles between beats -> no writes in gaps, pre_ready held, LAUNCH only after pre_last beat.
REQ-037 RES_BASE=254, NRES=3 -> read addresses 254,255,0 in order.
REQ-038 Reset mid-CLEAR (addr 100) and mid-RUN -> immediate IDLE, dut_start=1, mem_we=0; stray go during RUN ignored.

Source files
------------

// File: rtl/prog_run_ctrl_pkg.sv
// Shared state encoding and default build constants for the program-run controller.
package prog_run_pkg;

    localparam int DEF_DW       = 8;
    localparam int DEF_AW       = 8;
    localparam int DEF_NRES     = 3;
    localparam int DEF_RES_BASE = 4;
    localparam int DEF_TIMEOUT  = 100000;
    localparam int DEF_CW       = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_LAUNCH,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } run_state_t;

endpackage

// File: rtl/prog_run_ctrl_counter.sv
// Saturating run-cycle counter with a flag that marks the last permitted cycle.
module run_cycle_counter #(
    parameter int CW    = 32,
    parameter int LIMIT = 100000
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          limit_hit
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] LIM_M1  = CW'(LIMIT - 1);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CW'(1);
        end
    end

    // Asserted while the current run cycle is the final one allowed.
    assign limit_hit = (count == LIM_M1);

endmodule

// File: rtl/prog_run_ctrl.sv
// Sequencer that clears data memory, preloads it, runs the DUT to halt or
// timeout, then streams a block of result words back out.
module prog_run_ctrl
    import prog_run_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int NRES     = DEF_NRES,
    parameter int RES_BASE = DEF_RES_BASE,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CW       = DEF_CW
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  go,
    input  logic                  pre_valid,
    input  logic [AW-1:0]         pre_addr,
    input  logic [DW-1:0]         pre_data,
    input  logic                  pre_last,
    output logic                  pre_ready,
    output logic                  mem_own,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  dut_start,
    input  logic                  dut_halt,
    output logic                  res_valid,
    output logic [$clog2(NRES):0] res_idx,
    output logic [DW-1:0]         res_data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CW-1:0]         cycles
);

    localparam int             RIW      = $clog2(NRES) + 1;
    localparam logic [RIW-1:0] LAST_IDX = RIW'(NRES);
    localparam logic [AW-1:0]  RES_A0   = AW'(RES_BASE);

    run_state_t     state;
    logic [AW-1:0]  clr_addr;
    logic [RIW-1:0] dump_idx;
    logic           go_ok;
    logic           cnt_clear;
    logic           cnt_en;
    logic           limit_hit;

    assign go_ok     = go && ((state == ST_IDLE) || (state == ST_DONE));
    assign cnt_clear = go_ok || (state == ST_LAUNCH);
    assign cnt_en    = (state == ST_RUN);

    run_cycle_counter #(
        .CW    (CW),
        .LIMIT (TIMEOUT)
    ) u_run_cycle_counter (
        .CLK       (CLK),
        .Reset     (Reset),
        .clear     (cnt_clear),
        .enable    (cnt_en),
        .count     (cycles),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            clr_addr  <= '0;
            dump_idx  <= '0;
            timeout   <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                        dump_idx <= '0;
                        timeout  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == '1) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (pre_valid && pre_last) begin
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // A halt on the limit cycle is a normal finish, not a timeout.
                    if (dut_halt) begin
                        state    <= ST_DUMP;
                        dump_idx <= '0;
                    end else if (limit_hit) begin
                        state    <= ST_DUMP;
                        dump_idx <= '0;
                        timeout  <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    // Read data lags the address by one cycle, so each beat is
                    // flagged on the cycle after its address was issued.
                    if (dump_idx < LAST_IDX) begin
                        res_valid <= 1'b1;
                        res_idx   <= dump_idx;
                    end
                    if (dump_idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        dump_idx <= dump_idx + RIW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_data = res_valid ? mem_rdata : '0;

    always_comb begin
        pre_ready = 1'b0;
        mem_own   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        dut_start = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_own  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_addr;
                busy     = 1'b1;
            end
            ST_LOAD: begin
                pre_ready = 1'b1;
                mem_own   = 1'b1;
                mem_we    = pre_valid;
                mem_addr  = pre_valid ? pre_addr : '0;
                mem_wdata = pre_valid ? pre_data : '0;
                busy      = 1'b1;
            end
            ST_LAUNCH: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                dut_start = 1'b0;
                busy      = 1'b1;
            end
            ST_DUMP: begin
                mem_own = 1'b1;
                busy    = 1'b1;
                if (dump_idx < LAST_IDX) begin
                    mem_addr = RES_A0 + AW'(dump_idx);
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                dut_start = 1'b1;
            end
        endcase
    end

endmodule
